// File: rtl/eq_pkg.sv
// Shared execution-queue package.
// Purpose : common widths and the queue entry payload used by all execution queues.
// Contents: TAG_W, DATA_W, OPC_W and entry_t, which holds one queued instruction.
package eq_pkg;

    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 4;

    // One queued instruction with its operand capture state
    typedef struct packed {
        logic              busy;
        logic [OPC_W-1:0]  opcode;
        logic [TAG_W-1:0]  rdtag;
        logic [TAG_W-1:0]  rstag;
        logic [TAG_W-1:0]  rttag;
        logic [DATA_W-1:0] rsdata;
        logic [DATA_W-1:0] rtdata;
        logic              rsvalid;
        logic              rtvalid;
    } entry_t;

endpackage

// File: rtl/equeue_entry.sv
// Single execution-queue entry: storage plus CDB operand snoop.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   entry_d_i     next value for this slot, chosen by the queue (compaction/dispatch)
//   cdb_*_i       common data bus broadcast
//   entry_q_o     registered entry contents
//   wake_c_o      registered contents with this cycle's CDB capture applied (combinational)
module equeue_entry
    import eq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  entry_t            entry_d_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output entry_t            entry_q_o,
    output entry_t            wake_c_o
);

    entry_t entry_q;

    // Slot register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d_i;
        end
    end

    // Operand capture; rs and rt are checked independently
    always_comb begin
        wake_c_o = entry_q;
        if (entry_q.busy && cdb_valid_i) begin
            if (!entry_q.rsvalid && (entry_q.rstag == cdb_tag_i)) begin
                wake_c_o.rsvalid = 1'b1;
                wake_c_o.rsdata  = cdb_data_i;
            end
            if (!entry_q.rtvalid && (entry_q.rttag == cdb_tag_i)) begin
                wake_c_o.rtvalid = 1'b1;
                wake_c_o.rtdata  = cdb_data_i;
            end
        end
    end

    assign entry_q_o = entry_q;

endmodule

// File: rtl/equeue_int.sv
// Integer execution queue (reservation station), compacting and age ordered.
// Index 0 holds the oldest instruction; busy slots are contiguous from index 0.
// Optional feature macro: EQUEUEINT_CDB_BYPASS_EN enables capturing a same-cycle
// CDB result into a dispatched operand that is not yet valid.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   dispatch_*         new instruction from dispatch; dispatch_ready = free slot exists
//   cdb_*              common data bus broadcast snooped by all entries
//   issueint_*         oldest entry with both operands valid; zero when none
//   issueint_done      issue unit took the presented entry this cycle
module equeue_int
    import eq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPC_W-1:0]  dispatch_opcode,
    input  logic              dispatch_en,
    output logic              dispatch_ready,
    input  logic [TAG_W-1:0]  dispatch_rdtag,
    input  logic [TAG_W-1:0]  dispatch_rstag,
    input  logic [TAG_W-1:0]  dispatch_rttag,
    input  logic [DATA_W-1:0] dispatch_rsdata,
    input  logic [DATA_W-1:0] dispatch_rtdata,
    input  logic              dispatch_rsvalid,
    input  logic              dispatch_rtvalid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic              cdb_valid,
    input  logic [DATA_W-1:0] cdb_data,
    output logic [OPC_W-1:0]  issueint_opcode,
    output logic [TAG_W-1:0]  issueint_rdtag,
    output logic [DATA_W-1:0] issueint_rsdata,
    output logic [DATA_W-1:0] issueint_rtdata,
    output logic              issueint_ready,
    input  logic              issueint_done
);

    localparam int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           cur_q   [DEPTH];
    entry_t           wake_c  [DEPTH];
    entry_t           shift_c [DEPTH];
    entry_t           nxt_d   [DEPTH];
    entry_t           disp_c;
    entry_t           sel_entry_c;
    logic [SEL_W-1:0] sel_c;
    logic             sel_found_c;
    logic [CNT_W-1:0] count_c;
    logic [CNT_W-1:0] tail_c;
    logic             remove_c;

    // Entry storage and CDB snoop
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        equeue_entry u_entry (
            .clk         (clk),
            .reset       (reset),
            .entry_d_i   (nxt_d[g]),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_data_i  (cdb_data),
            .entry_q_o   (cur_q[g]),
            .wake_c_o    (wake_c[g])
        );
    end

    // Occupancy and oldest-ready selection from registered state only
    always_comb begin
        count_c     = '0;
        sel_c       = '0;
        sel_found_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            count_c = count_c + CNT_W'(cur_q[i].busy);
            if (!sel_found_c && cur_q[i].busy && cur_q[i].rsvalid && cur_q[i].rtvalid) begin
                sel_c       = SEL_W'(i);
                sel_found_c = 1'b1;
            end
        end
    end

    assign sel_entry_c     = sel_found_c ? cur_q[sel_c] : '0;
    assign issueint_ready  = sel_found_c;
    assign issueint_opcode = sel_entry_c.opcode;
    assign issueint_rdtag  = sel_entry_c.rdtag;
    assign issueint_rsdata = sel_entry_c.rsdata;
    assign issueint_rtdata = sel_entry_c.rtdata;

    assign dispatch_ready  = (count_c < CNT_W'(DEPTH));
    assign remove_c        = issueint_done & sel_found_c;
    assign tail_c          = count_c - CNT_W'(remove_c);

    // Dispatched entry, optionally capturing a same-cycle CDB result
    always_comb begin
        disp_c         = '0;
        disp_c.busy    = 1'b1;
        disp_c.opcode  = dispatch_opcode;
        disp_c.rdtag   = dispatch_rdtag;
        disp_c.rstag   = dispatch_rstag;
        disp_c.rttag   = dispatch_rttag;
        disp_c.rsdata  = dispatch_rsdata;
        disp_c.rtdata  = dispatch_rtdata;
        disp_c.rsvalid = dispatch_rsvalid;
        disp_c.rtvalid = dispatch_rtvalid;
`ifdef EQUEUEINT_CDB_BYPASS_EN
        if (cdb_valid && !dispatch_rsvalid && (dispatch_rstag == cdb_tag)) begin
            disp_c.rsvalid = 1'b1;
            disp_c.rsdata  = cdb_data;
        end
        if (cdb_valid && !dispatch_rtvalid && (dispatch_rttag == cdb_tag)) begin
            disp_c.rtvalid = 1'b1;
            disp_c.rtdata  = cdb_data;
        end
`endif
    end

    // Compaction of woken entries past the removed slot, then tail write
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            shift_c[i] = wake_c[i];
        end
        if (remove_c) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (SEL_W'(i) >= sel_c) begin
                    shift_c[i] = wake_c[i + 1];
                end
            end
            shift_c[DEPTH - 1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            nxt_d[i] = shift_c[i];
            if (dispatch_en && dispatch_ready && (CNT_W'(i) == tail_c)) begin
                nxt_d[i] = disp_c;
            end
        end
    end

endmodule

// File: tb/tb_equeue_int.sv
// Testbench for equeue_int: scoreboard of expected issue order, compared when issued.
module tb_equeue_int;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [3:0]  op;
        logic [5:0]  rd;
        logic [31:0] rs;
        logic [31:0] rt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  dispatch_opcode;
    logic        dispatch_en;
    logic        dispatch_ready;
    logic [5:0]  dispatch_rdtag;
    logic [5:0]  dispatch_rstag;
    logic [5:0]  dispatch_rttag;
    logic [31:0] dispatch_rsdata;
    logic [31:0] dispatch_rtdata;
    logic        dispatch_rsvalid;
    logic        dispatch_rtvalid;
    logic [5:0]  cdb_tag;
    logic        cdb_valid;
    logic [31:0] cdb_data;
    logic [3:0]  issueint_opcode;
    logic [5:0]  issueint_rdtag;
    logic [31:0] issueint_rsdata;
    logic [31:0] issueint_rtdata;
    logic        issueint_ready;
    logic        issueint_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    equeue_int #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .dispatch_opcode  (dispatch_opcode),
        .dispatch_en      (dispatch_en),
        .dispatch_ready   (dispatch_ready),
        .dispatch_rdtag   (dispatch_rdtag),
        .dispatch_rstag   (dispatch_rstag),
        .dispatch_rttag   (dispatch_rttag),
        .dispatch_rsdata  (dispatch_rsdata),
        .dispatch_rtdata  (dispatch_rtdata),
        .dispatch_rsvalid (dispatch_rsvalid),
        .dispatch_rtvalid (dispatch_rtvalid),
        .cdb_tag          (cdb_tag),
        .cdb_valid        (cdb_valid),
        .cdb_data         (cdb_data),
        .issueint_opcode  (issueint_opcode),
        .issueint_rdtag   (issueint_rdtag),
        .issueint_rsdata  (issueint_rsdata),
        .issueint_rtdata  (issueint_rtdata),
        .issueint_ready   (issueint_ready),
        .issueint_done    (issueint_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge, strobes drop
    task automatic step();
        @(posedge clk);
        #1;
        dispatch_en   = 1'b0;
        cdb_valid     = 1'b0;
        issueint_done = 1'b0;
    endtask

    task automatic drive_disp(input logic [3:0] op, input logic [5:0] rd,
                              input logic [5:0] rst, input logic [5:0] rtt,
                              input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic rsv, input logic rtv);
        dispatch_en      = 1'b1;
        dispatch_opcode  = op;
        dispatch_rdtag   = rd;
        dispatch_rstag   = rst;
        dispatch_rttag   = rtt;
        dispatch_rsdata  = rsd;
        dispatch_rtdata  = rtd;
        dispatch_rsvalid = rsv;
        dispatch_rtvalid = rtv;
    endtask

    task automatic drive_cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    // Compare the presented entry with the scoreboard head, then accept it
    task automatic pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ".ready"}, 32'(issueint_ready), 32'd1);
            check({tag, ".op"},    32'(issueint_opcode), 32'(e.op));
            check({tag, ".rd"},    32'(issueint_rdtag), 32'(e.rd));
            check({tag, ".rs"},    issueint_rsdata, e.rs);
            check({tag, ".rt"},    issueint_rtdata, e.rt);
        end
        issueint_done = 1'b1;
        step();
    endtask

    initial begin
        // Reset with garbage on every input
        reset = 1'b1;
        drive_disp(4'hF, 6'h3F, 6'h3F, 6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        drive_cdb(6'h3F, 32'hFFFF_FFFF);
        issueint_done = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.dispatch_ready", 32'(dispatch_ready), 32'd1);
        check("rst.issue_ready",    32'(issueint_ready), 32'd0);
        check("rst.rsdata",         issueint_rsdata, 32'd0);
        reset = 1'b0;
        dispatch_en   = 1'b0;
        cdb_valid     = 1'b0;
        issueint_done = 1'b0;
        step();
        check("post_rst.issue_ready", 32'(issueint_ready), 32'd0);

        // Basic dispatch with both operands ready: 1-cycle latency
        drive_disp(4'h2, 6'd5, 6'd1, 6'd2, 32'd7, 32'd9, 1'b1, 1'b1);
        sb.push_back('{op: 4'h2, rd: 6'd5, rs: 32'd7, rt: 32'd9});
        step();
        pop("basic");
        check("basic.empty_after_done", 32'(issueint_ready), 32'd0);

        // CDB wakeup of rs; a done with nothing ready must be ignored
        drive_disp(4'h9, 6'd30, 6'd12, 6'd13, 32'h0, 32'h99, 1'b0, 1'b1);
        step();
        check("wake.not_ready", 32'(issueint_ready), 32'd0);
        check("wake.zero_rd",   32'(issueint_rdtag), 32'd0);
        issueint_done = 1'b1;
        step();
        check("wake.done_ignored", 32'(issueint_ready), 32'd0);
        drive_cdb(6'd12, 32'hDEAD);
        sb.push_back('{op: 4'h9, rd: 6'd30, rs: 32'hDEAD, rt: 32'h99});
        check("wake.not_ready_in_cdb_cycle", 32'(issueint_ready), 32'd0);
        step();
        pop("wake");

        // Fill the queue; entry 1 ready first, entry 0 waits on tag 3
        drive_disp(4'h1, 6'd10, 6'd3, 6'd0, 32'h0, 32'h11, 1'b0, 1'b1);
        step();
        drive_disp(4'h3, 6'd11, 6'd0, 6'd0, 32'h21, 32'h22, 1'b1, 1'b1);
        sb.push_back('{op: 4'h3, rd: 6'd11, rs: 32'h21, rt: 32'h22});
        step();
        drive_disp(4'h4, 6'd12, 6'd3, 6'd3, 32'h31, 32'h32, 1'b1, 1'b1);
        sb.push_back('{op: 4'h4, rd: 6'd12, rs: 32'h31, rt: 32'h32});
        step();
        check("fill.ready_before_last", 32'(dispatch_ready), 32'd1);
        drive_disp(4'h5, 6'd13, 6'd20, 6'd3, 32'h0, 32'h42, 1'b0, 1'b1);
        step();
        check("fill.full", 32'(dispatch_ready), 32'd0);
        // Dispatch while full is dropped even though a removal happens this cycle
        drive_disp(4'hE, 6'd63, 6'd0, 6'd0, 32'hBAD, 32'hBAD, 1'b1, 1'b1);
        pop("fill.e1");
        check("fill.ready_after_removal", 32'(dispatch_ready), 32'd1);
        pop("fill.e2");
        check("fill.e0_still_waiting", 32'(issueint_ready), 32'd0);
        drive_cdb(6'd3, 32'hAAAA);
        sb.push_back('{op: 4'h1, rd: 6'd10, rs: 32'hAAAA, rt: 32'h11});
        step();
        pop("fill.e0");
        check("fill.e3_waiting", 32'(issueint_ready), 32'd0);
        drive_cdb(6'd20, 32'hBBBB);
        sb.push_back('{op: 4'h5, rd: 6'd13, rs: 32'hBBBB, rt: 32'h42});
        step();
        pop("fill.e3");
        check("fill.drained", 32'(issueint_ready), 32'd0);

        // Same cycle: removal, dispatch and wakeup of a younger entry
        drive_disp(4'h6, 6'd20, 6'd0, 6'd0, 32'h51, 32'h52, 1'b1, 1'b1);
        sb.push_back('{op: 4'h6, rd: 6'd20, rs: 32'h51, rt: 32'h52});
        step();
        drive_disp(4'h7, 6'd21, 6'd40, 6'd0, 32'h0, 32'h62, 1'b0, 1'b1);
        step();
        drive_disp(4'h8, 6'd22, 6'd0, 6'd0, 32'h71, 32'h72, 1'b1, 1'b1);
        drive_cdb(6'd40, 32'hC0DE);
        pop("simul.a");
        sb.push_back('{op: 4'h7, rd: 6'd21, rs: 32'hC0DE, rt: 32'h62});
        sb.push_back('{op: 4'h8, rd: 6'd22, rs: 32'h71, rt: 32'h72});
        // Two entries remain: two more dispatches must fill the queue
        drive_disp(4'hA, 6'd23, 6'd50, 6'd0, 32'h0, 32'h82, 1'b0, 1'b1);
        step();
        check("simul.count2_not_full", 32'(dispatch_ready), 32'd1);
        drive_disp(4'hB, 6'd24, 6'd0, 6'd50, 32'h91, 32'h0, 1'b1, 1'b0);
        step();
        check("simul.full", 32'(dispatch_ready), 32'd0);
        pop("simul.b");
        pop("simul.c");
        check("simul.waiting", 32'(issueint_ready), 32'd0);
        drive_cdb(6'd50, 32'h5050);
        sb.push_back('{op: 4'hA, rd: 6'd23, rs: 32'h5050, rt: 32'h82});
        sb.push_back('{op: 4'hB, rd: 6'd24, rs: 32'h91, rt: 32'h5050});
        step();
        pop("simul.d");
        pop("simul.e");

        // Dispatch with a same-cycle CDB broadcast of the missing operand
        drive_disp(4'hC, 6'd33, 6'd8, 6'd0, 32'h0, 32'h77, 1'b0, 1'b1);
        drive_cdb(6'd8, 32'h88);
`ifdef EQUEUEINT_CDB_BYPASS_EN
        sb.push_back('{op: 4'hC, rd: 6'd33, rs: 32'h88, rt: 32'h77});
        step();
        pop("bypass");
`else
        step();
        check("nobypass.not_ready", 32'(issueint_ready), 32'd0);
        drive_cdb(6'd8, 32'h808);
        sb.push_back('{op: 4'hC, rd: 6'd33, rs: 32'h808, rt: 32'h77});
        step();
        pop("nobypass");
`endif

        // Asynchronous reset in the middle of operation
        drive_disp(4'hD, 6'd40, 6'd0, 6'd0, 32'h123, 32'h456, 1'b1, 1'b1);
        step();
        check("midrst.before", 32'(issueint_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst.issue_ready", 32'(issueint_ready), 32'd0);
        check("midrst.dispatch_ready", 32'(dispatch_ready), 32'd1);
        check("midrst.rsdata", issueint_rsdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("midrst.after", 32'(issueint_ready), 32'd0);
        check("sb.drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/equeue_int.md
# equeue_int

Integer execution queue (reservation station) of the out-of-order core, between dispatch and the integer issue unit. It holds up to DEPTH dispatched integer instructions and snoops the common data bus (CDB) to collect missing source operands. It presents the oldest instruction with both operands valid to the integer issue unit, and retires that entry when the issue unit signals done.

## Interface
- DEPTH, 4: number of queue entries (2..16).
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- dispatch_opcode  in  4  integer ALU opcode, passed through unchanged.
- dispatch_en  in  1  write request; honoured only when dispatch_ready=1.
- dispatch_ready  out  1  queue can accept an entry this cycle.
- dispatch_rdtag / dispatch_rstag / dispatch_rttag  in  6 each  destination and source tags.
- dispatch_rsdata / dispatch_rtdata  in  32 each  source data, meaningful when the matching valid bit is 1.
- dispatch_rsvalid / dispatch_rtvalid  in  1 each  source operand already available.
- cdb_tag  in  6  tag of the result on the CDB.
- cdb_valid  in  1  CDB carries a valid result this cycle.
- cdb_data  in  32  result data.
- issueint_opcode  out  4  opcode of the selected entry.
- issueint_rdtag  out  6  destination tag of the selected entry.
- issueint_rsdata / issueint_rtdata  out  32 each  operands of the selected entry.
- issueint_ready  out  1  a selected entry exists (both operands valid).
- issueint_done  in  1  issue unit accepted the selected entry this cycle.

## Operation
- Each entry holds: busy, opcode, rdtag, rstag, rttag, rsdata, rtdata, rsvalid, rtvalid.
- Entries form a compacting age-ordered queue. Index 0 is the oldest entry. Busy entries are always contiguous from index 0.
- Selection: the lowest-index busy entry with rsvalid&rtvalid. issueint_ready=1 and the issue outputs show that entry, combinationally from registered state. With no selection, issueint_ready=0 and all issue data outputs are 0.
- Removal: issueint_done=1 while issueint_ready=1 frees the selected entry at the edge. All younger entries shift down one index. issueint_done while issueint_ready=0 is ignored.
- dispatch_ready = (count < DEPTH); it is registered-state based only and does not account for a same-cycle removal.
- Dispatch: dispatch_en & dispatch_ready writes the new entry at the first free index after this cycle's removal/compaction.
- CDB wakeup: with cdb_valid=1, every busy entry whose operand is invalid and whose tag equals cdb_tag loads cdb_data and sets that operand's valid bit. rs and rt are handled independently; both may match in the same cycle.
- Simultaneous events: wakeup, removal and dispatch in the same cycle are all applied. Wakeup applies to the entry's data before it shifts. An entry woken this cycle is not selectable until the next cycle.
- Reset (including mid-operation): all busy bits clear immediately. dispatch_ready=1, issueint_ready=0, issue data outputs 0.

## Timing
- Dispatch of an entry with both operands valid into an empty queue: issueint_ready=1 in the cycle after the dispatch edge (1-cycle latency).
- CDB wakeup at edge N: the entry is selectable from cycle N+1.
- Removal at edge N: the next selection is visible in cycle N+1.
- Full queue: dispatch_ready=0 until the cycle after a removal.

## Configuration
- EQUEUEINT_CDB_BYPASS_EN defined: at dispatch, an operand with valid=0 whose tag matches cdb_tag while cdb_valid=1 is written as valid with cdb_data.
- Not defined: no dispatch-time capture; the operand is written invalid. The dispatch unit guarantees it never dispatches an operand whose producer broadcasts in that same cycle.

## Structure
- Shared package (eq_pkg): TAG_W=6, DATA_W=32, OPC_W=4, and the entry struct typedef. All execution queues use it.
- Sub-module equeue_entry: one entry's storage plus its CDB tag compare, instantiated DEPTH times. Selection and compaction live in the top.

## Test plan
- Reset with garbage on inputs -> dispatch_ready=1, issueint_ready=0, issueint_rsdata=0.
- Dispatch opcode=4'h2, rd=6'd5, rs=32'd7, rt=32'd9, both valid -> next cycle issueint_ready=1 with rdtag 5 and data 7/9. Pulse done -> ready=0 next cycle.
- Dispatch rstag=6'd12 invalid, rt valid. Drive cdb_valid=1, cdb_tag=12, cdb_data=32'hDEAD -> ready rises the following cycle with rsdata=32'hDEAD.
- Fill DEPTH entries, oldest waiting on tag 3, entry 1 ready -> entry 1 selected first, dispatch_ready=0. Done -> dispatch_ready=1 next cycle, order preserved.
- Same cycle: done, dispatch, and a CDB broadcast matching a younger entry -> count unchanged, younger entry woken and shifted, new entry at the tail.
- With EQUEUEINT_CDB_BYPASS_EN: dispatch rstag=8 invalid while the CDB broadcasts tag 8 -> entry ready next cycle. Without the macro -> entry stays not ready.
